// File: rtl/mux4_select.sv
// mux4_select: bit-level N:1 multiplexer with a zero-latency combinational
// output, plus a registered copy of that output and a registered
// select-out-of-range flag for synchronous consumers.
module mux4_select #(
  parameter int NUM_INPUTS = 4,
  parameter int SEL_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] in,
  input  logic [SEL_W-1:0]      select,
  input  logic                  en,
  output logic                  out,
  output logic                  out_q,
  output logic                  sel_err
);

  // Reject illegal parameterisations at elaboration time.
  if ((NUM_INPUTS < 2) || (NUM_INPUTS > 64)) begin : g_bad_num_inputs
    $fatal(1, "mux4_select: NUM_INPUTS must lie in 2..64");
  end
  if ((2 ** SEL_W) < NUM_INPUTS) begin : g_bad_sel_w
    $fatal(1, "mux4_select: SEL_W too narrow to address NUM_INPUTS");
  end

  logic out_s;        // combinational selected bit
  logic sel_legal_s;  // select addresses an existing input
  logic out_val_d;
  logic out_val_q;
  logic sel_err_d;
  logic sel_err_q;

  // AND-OR decode: only a matching index contributes, so an out-of-range
  // select yields 0 and the whole path stays a pure mux with no latch.
  always_comb begin
    out_s       = 1'b0;
    sel_legal_s = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      out_s       = out_s | (in[i] & (select == SEL_W'(i)));
      sel_legal_s = sel_legal_s | (select == SEL_W'(i));
    end
  end

  // Next-state for the registered path: capture on en, otherwise hold.
  always_comb begin
    out_val_d = out_val_q;
    sel_err_d = sel_err_q;
    if (en) begin
      out_val_d = out_s;
      sel_err_d = ~sel_legal_s;
    end else begin
      out_val_d = out_val_q;
      sel_err_d = sel_err_q;
    end
  end

  // Output flops with synchronous reset taking priority over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_val_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      out_val_q <= out_val_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign out     = out_s;
  assign out_q   = out_val_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux4_select.sv
// Directed self-checking bench for mux4_select: a default 4:1 instance and
// a 3-input instance that exercises the out-of-range select flag.
module tb_mux4_select;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_s;
  logic [1:0] sel_s;
  logic       en_s;
  logic       out_s;
  logic       out_q_s;
  logic       sel_err_s;

  logic [2:0] in3_s;
  logic [1:0] sel3_s;
  logic       en3_s;
  logic       out3_s;
  logic       out_q3_s;
  logic       sel_err3_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux4_select #(.NUM_INPUTS(4), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .in(in_s), .select(sel_s), .en(en_s),
    .out(out_s), .out_q(out_q_s), .sel_err(sel_err_s)
  );

  mux4_select #(.NUM_INPUTS(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .in(in3_s), .select(sel3_s), .en(en3_s),
    .out(out3_s), .out_q(out_q3_s), .sel_err(sel_err3_s)
  );

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge, sampling away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en_s = 1'b0; in_s = 4'b0000; sel_s = 2'b00;
    en3_s = 1'b0; in3_s = 3'b000; sel3_s = 2'b00;

    // Exhaustive combinational sweep (held in reset; out must not care).
    for (int iv = 0; iv < 16; iv++) begin
      for (int sv = 0; sv < 4; sv++) begin
        in_s  = 4'(iv);
        sel_s = 2'(sv);
        #10;
        check_bit("sweep_out", out_s, 1'((iv >> sv) & 1));
      end
    end
    in_s = 4'b1010; sel_s = 2'b01; #10; check_bit("ex_1010_s1", out_s, 1'b1);
    sel_s = 2'b10;                 #10; check_bit("ex_1010_s2", out_s, 1'b0);

    // Reset state.
    repeat (2) tick();
    check_bit("rst_out_q", out_q_s, 1'b0);
    check_bit("rst_sel_err", sel_err_s, 1'b0);
    check_bit("rst_out_q3", out_q3_s, 1'b0);
    check_bit("rst_sel_err3", sel_err3_s, 1'b0);

    // Registered path, one-cycle latency.
    rst = 1'b0; en_s = 1'b1; in_s = 4'b0100; sel_s = 2'b10;
    tick();
    check_bit("reg_s2_q", out_q_s, 1'b1);
    check_bit("reg_s2_err", sel_err_s, 1'b0);
    sel_s = 2'b00;
    tick();
    check_bit("reg_s0_q", out_q_s, 1'b0);
    sel_s = 2'b11; in_s = 4'b1000;
    tick();
    check_bit("reg_s3_q", out_q_s, 1'b1);
    check_bit("reg_s3_err", sel_err_s, 1'b0);

    // Enable hold.
    in_s = 4'b0100; sel_s = 2'b10;
    tick();
    check_bit("hold_pre_q", out_q_s, 1'b1);
    en_s = 1'b0; in_s = 4'b0000;
    #1;
    check_bit("hold_out_drop", out_s, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_bit("hold_q", out_q_s, 1'b1);
    end
    en_s = 1'b1;
    tick();
    check_bit("hold_release_q", out_q_s, 1'b0);

    // Reset priority over enable; out keeps tracking during reset.
    in_s = 4'b0100; sel_s = 2'b10;
    tick();
    check_bit("prio_pre_q", out_q_s, 1'b1);
    rst = 1'b1;
    tick();
    check_bit("prio_q", out_q_s, 1'b0);
    check_bit("prio_err", sel_err_s, 1'b0);
    check_bit("prio_out", out_s, 1'b1);
    in_s = 4'b0000;
    #1;
    check_bit("prio_out_track", out_s, 1'b0);
    rst = 1'b0;

    // Non-power-of-two instance: out-of-range select.
    en3_s = 1'b1; in3_s = 3'b111; sel3_s = 2'b11;
    #1;
    check_bit("np2_out_oor", out3_s, 1'b0);
    tick();
    check_bit("np2_err_set", sel_err3_s, 1'b1);
    check_bit("np2_q_oor", out_q3_s, 1'b0);
    in3_s = 3'b100; sel3_s = 2'b10;
    #1;
    check_bit("np2_out_s2", out3_s, 1'b1);
    tick();
    check_bit("np2_err_clr", sel_err3_s, 1'b0);
    check_bit("np2_q_s2", out_q3_s, 1'b1);
    sel3_s = 2'b11; en3_s = 1'b0;
    tick();
    check_bit("np2_err_hold", sel_err3_s, 1'b0);
    en3_s = 1'b1;
    tick();
    check_bit("np2_err_reset_set", sel_err3_s, 1'b1);
    rst = 1'b1;
    tick();
    check_bit("np2_err_rst", sel_err3_s, 1'b0);
    rst = 1'b0;

    // Simultaneous change of in and select.
    en_s = 1'b0; in_s = 4'b0001; sel_s = 2'b00;
    #1;
    check_bit("simul_pre_out", out_s, 1'b1);
    check_bit("simul_pre_q", out_q_s, 1'b0);
    in_s = 4'b1000; sel_s = 2'b11;
    #1;
    check_bit("simul_out", out_s, 1'b1);
    en_s = 1'b1;
    tick();
    check_bit("simul_q", out_q_s, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
